noc_packet_buffer: RTL and testbench

//  Store-and-forward flit buffer for one NoC channel. It sits between the mesh

---
 rtl/noc_packet_buffer.sv | 122 ++++++++++++
 tb/tb_noc_packet_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_buffer.sv
// rtl/noc_packet_buffer.sv - store-and-forward flit buffer with cut-through escape for one NoC channel
module noc_packet_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FLIT_WIDTH-1:0]    in_flit,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [FLIT_WIDTH-1:0]    out_flit,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [$clog2(DEPTH):0]   pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // IDLE: head of buffer is a packet head, released only when complete
    // (or when the buffer is full). CUT: a packet is mid-way out and streams.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CUT  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [FLIT_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       fill_q, pkt_q;
    logic [FLIT_WIDTH:0] head;
    logic                wr_fire, rd_fire;
    logic                pkt_inc, pkt_dec;

    // Head flit is read straight from the RAM; no output register.
    assign head       = mem[rd_ptr];
    assign out_flit   = head[FLIT_WIDTH-1:0];
    assign out_last   = head[FLIT_WIDTH];

    assign in_ready   = (fill_q != FULL);
    assign fill_level = fill_q;
    assign pkt_count  = pkt_q;

    assign wr_fire    = in_valid & in_ready;
    assign rd_fire    = out_valid & out_ready;
    assign pkt_inc    = wr_fire & in_last;
    assign pkt_dec    = rd_fire & out_last;

    // RAM write port; contents survive reset, only pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= {in_last, in_flit};
        end
    end

    // Pointers, occupancy and complete-packet count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
            pkt_q  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_fire && !rd_fire) begin
                fill_q <= fill_q + CW'(1);
            end else if (!wr_fire && rd_fire) begin
                fill_q <= fill_q - CW'(1);
            end
            if (pkt_inc && !pkt_dec) begin
                pkt_q <= pkt_q + CW'(1);
            end else if (!pkt_inc && pkt_dec) begin
                pkt_q <= pkt_q - CW'(1);
            end
        end
    end

    // Release state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output release rule and IDLE/CUT transitions.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Full buffer with no complete packet would deadlock, so
                // let its head out and switch to streaming.
                out_valid = (fill_q != '0) && ((pkt_q != '0) || (fill_q == FULL));
                if (out_valid && out_ready && !out_last && (pkt_q == '0)) begin
                    state_d = ST_CUT;
                end
            end
            ST_CUT: begin
                out_valid = (fill_q != '0);
                if (out_valid && out_ready && out_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_noc_packet_buffer.sv
// tb/tb_noc_packet_buffer.sv - self-checking bench for noc_packet_buffer
module tb_noc_packet_buffer;

    localparam int FW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] drv_flit = '0;
    logic          drv_last = 1'b0;
    logic          drv_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] out_flit;
    logic          out_last;
    logic          out_valid;
    logic          drv_oready = 1'b0;
    logic [CW-1:0] fill_level;
    logic [CW-1:0] pkt_count;

    noc_packet_buffer #(.FLIT_WIDTH(FW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_flit    (drv_flit),
        .in_last    (drv_last),
        .in_valid   (drv_valid),
        .in_ready   (in_ready),
        .out_flit   (out_flit),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (drv_oready),
        .fill_level (fill_level),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: buffer contents as an ordered queue of {last, flit}.
    logic [FW:0] mq [$];
    logic [FW:0] src [$];
    bit          mid = 1'b0;
    bit          last_wr, last_rd;

    typedef struct {
        logic          iv;
        logic [FW-1:0] fl;
        logic          il;
        logic          ordy;
        logic          ov;
        int            fill;
        int            pkt;
        logic [FW-1:0] oflit;
        logic          olast;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_pkts();
        int n = 0;
        foreach (mq[i]) if (mq[i][FW]) n++;
        return n;
    endfunction

    // Head visible if its packet is complete, buffer is full, or a packet is mid-transfer.
    function automatic bit m_ov();
        return (mq.size() != 0) && (mid || (m_pkts() != 0) || (mq.size() == DEPTH));
    endfunction

    task automatic check_state();
        bit exp_ov;
        exp_ov = m_ov();
        chk("fill_level", 64'(fill_level), 64'(mq.size()));
        chk("pkt_count", 64'(pkt_count), 64'(m_pkts()));
        chk("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("out_flit", 64'(out_flit), 64'(mq[0][FW-1:0]));
            chk("out_last", 64'(out_last), 64'(mq[0][FW]));
        end
        chk("pkt_le_fill", 64'(pkt_count <= fill_level), 64'(1));
        chk("fill_le_depth", 64'(fill_level <= CW'(DEPTH)), 64'(1));
    endtask

    task automatic cycle();
        bit          wr, rd;
        logic [FW:0] wv, pv;
        wr = drv_valid && (mq.size() != DEPTH);
        rd = m_ov() && drv_oready;
        wv = {drv_last, drv_flit};
        @(posedge clk);
        #1;
        if (rd) begin
            pv  = mq.pop_front();
            mid = !pv[FW];
        end
        if (wr) mq.push_back(wv);
        last_wr = wr;
        last_rd = rd;
        check_state();
    endtask

    task automatic drive(input int pv, input int pr);
        drv_oready = ($urandom_range(99) < pr);
        if ((src.size() > 0) && ($urandom_range(99) < pv)) begin
            drv_valid = 1'b1;
            drv_last  = src[0][FW];
            drv_flit  = src[0][FW-1:0];
        end else begin
            drv_valid = 1'b0;
            drv_last  = 1'($urandom);
            drv_flit  = $urandom;
        end
    endtask

    task automatic step(input int pv, input int pr);
        drive(pv, pr);
        cycle();
        if (last_wr) void'(src.pop_front());
    endtask

    task automatic add_pkt(input int len);
        for (int i = 0; i < len; i++) begin
            src.push_back({(i == len - 1) ? 1'b1 : 1'b0, 32'($urandom)});
        end
    endtask

    task automatic drain(input int pv, input int pr, input int bound, input string name);
        int n = 0;
        while (((src.size() > 0) || (mq.size() > 0)) && (n < bound)) begin
            step(pv, pr);
            n++;
        end
        checks++;
        if ((src.size() > 0) || (mq.size() > 0)) begin
            errors++;
            $display("FAIL %s drain timeout: %0d flits left expected 0", name, src.size() + mq.size());
        end
    endtask

    initial begin
        int n;
        int maxf;
        int rd_cnt;
        int both;

        tbl[0] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 1, 0, 32'h0,  1'b0};
        tbl[1] = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 2, 0, 32'h0,  1'b0};
        tbl[2] = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 3, 1, 32'hA1, 1'b0};
        tbl[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 2, 1, 32'hA2, 1'b0};
        tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1, 1, 32'hA3, 1'b1};
        tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 0, 0, 32'h0,  1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_state();

        // 1: three-flit packet released only after its tail
        for (int i = 0; i < 6; i++) begin
            drv_valid  = tbl[i].iv;
            drv_flit   = tbl[i].fl;
            drv_last   = tbl[i].il;
            drv_oready = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("t1[%0d] out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("t1[%0d] fill", i), 64'(fill_level), 64'(tbl[i].fill));
            chk($sformatf("t1[%0d] pkt", i), 64'(pkt_count), 64'(tbl[i].pkt));
            if (tbl[i].ov) begin
                chk($sformatf("t1[%0d] flit", i), 64'(out_flit), 64'(tbl[i].oflit));
                chk($sformatf("t1[%0d] last", i), 64'(out_last), 64'(tbl[i].olast));
            end
        end
        drv_valid = 1'b0;

        // 2: fill with four 4-flit packets, then drain
        for (int p = 0; p < 4; p++) add_pkt(4);
        n = 0;
        while ((src.size() > 0) && (n < 40)) begin
            step(100, 0);
            n++;
        end
        chk("t2 full fill", 64'(fill_level), 64'(16));
        chk("t2 full pkt", 64'(pkt_count), 64'(4));
        chk("t2 full in_ready", 64'(in_ready), 64'(0));
        add_pkt(1);
        step(100, 0);
        step(100, 0);
        chk("t2 ignored write fill", 64'(fill_level), 64'(16));
        src.delete();
        step(0, 100);
        chk("t2 in_ready after read", 64'(in_ready), 64'(1));
        drain(0, 100, 40, "t2");

        // 3: 20-flit packet forces the cut-through escape
        add_pkt(20);
        maxf   = 0;
        rd_cnt = 0;
        n      = 0;
        while (((src.size() > 0) || (mq.size() > 0)) && (n < 100)) begin
            step(100, 100);
            if (int'(fill_level) > maxf) maxf = int'(fill_level);
            if (last_rd) rd_cnt++;
            n++;
        end
        chk("t3 max fill", 64'(maxf), 64'(16));
        chk("t3 flits out", 64'(rd_cnt), 64'(20));
        add_pkt(2);
        step(100, 100);
        chk("t3 idle after tail", 64'(out_valid), 64'(0));
        drain(100, 100, 20, "t3b");

        // 4: back-to-back single-flit packets across pointer wrap
        for (int p = 0; p < 48; p++) add_pkt(1);
        both = 0;
        n    = 0;
        while ((src.size() > 0) && (n < 100)) begin
            step(100, 100);
            if (last_wr && last_rd) begin
                both++;
                chk("t4 steady fill", 64'(fill_level), 64'(1));
            end
            n++;
        end
        chk("t4 simultaneous cycles", 64'(both >= 40), 64'(1));
        drain(0, 100, 20, "t4");

        // 5: asynchronous reset mid-packet
        add_pkt(4);
        add_pkt(10);
        for (int i = 0; i < 7; i++) step(100, 0);
        chk("t5 pre-reset fill", 64'(fill_level), 64'(7));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 async fill", 64'(fill_level), 64'(0));
        chk("t5 async pkt", 64'(pkt_count), 64'(0));
        chk("t5 async out_valid", 64'(out_valid), 64'(0));
        chk("t5 async in_ready", 64'(in_ready), 64'(1));
        mq.delete();
        src.delete();
        mid = 1'b0;
        drv_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        add_pkt(2);
        drain(100, 100, 20, "t5");

        // 6: random traffic with lengths 1..24
        for (int p = 0; p < 30; p++) add_pkt(int'($urandom_range(24, 1)));
        drain(50, 50, 6000, "t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
